// File: rtl/vga_timing_monitor.sv
// Sink-side VGA stream monitor: recovers active-pixel coordinates, measures line/frame
// timing and locks after consecutive good frames. Define VGA_FRAME_CRC_EN for per-frame CRC.
module vga_timing_monitor #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2,
    parameter int TIMEOUT     = 840000
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iHS,
    input  logic        iVS,
    input  logic        iBLANK_n,
    input  logic [7:0]  iR,
    input  logic [7:0]  iG,
    input  logic [7:0]  iB,
    output logic        oDE,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic        oFRAME_START,
    output logic        oLOCKED,
    output logic        oERR,
    output logic [10:0] oLINE_LEN,
    output logic [9:0]  oACTIVE_LINES,
    output logic [7:0]  oERR_CNT,
    output logic [15:0] oFRAME_CRC,
    output logic        oCRC_VALID
);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    function automatic logic [9:0] inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [10:0] inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    logic hs_s1, vs_s1, blank_s1;
    logic hs_s1_d, vs_s1_d, blank_s1_d;
    logic hs_fall, vs_fall, blank_fall;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hs_s1      <= 1'b0;
            vs_s1      <= 1'b0;
            blank_s1   <= 1'b0;
            hs_s1_d    <= 1'b0;
            vs_s1_d    <= 1'b0;
            blank_s1_d <= 1'b0;
        end else begin
            hs_s1      <= iHS;
            vs_s1      <= iVS;
            blank_s1   <= iBLANK_n;
            hs_s1_d    <= hs_s1;
            vs_s1_d    <= vs_s1;
            blank_s1_d <= blank_s1;
        end
    end

    assign hs_fall    = hs_s1_d & ~hs_s1;
    assign vs_fall    = vs_s1_d & ~vs_s1;
    assign blank_fall = blank_s1_d & ~blank_s1;

    // Coordinate recovery; the visible oX/oY only move while a pixel is being presented.
    logic [9:0] px_cnt, line_cnt, x_cur, y_cur;

    assign x_cur = hs_fall ? 10'd0 : px_cnt;
    assign y_cur = vs_fall ? 10'd0 : line_cnt;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            px_cnt   <= 10'd0;
            line_cnt <= 10'd0;
            oDE      <= 1'b0;
            oX       <= 10'd0;
            oY       <= 10'd0;
        end else begin
            oDE <= blank_s1;
            if (blank_s1) begin
                oX     <= x_cur;
                oY     <= y_cur;
                px_cnt <= inc10(x_cur);
            end else begin
                px_cnt <= x_cur;
            end
            if (vs_fall)
                line_cnt <= 10'd0;
            else if (blank_fall)
                line_cnt <= inc10(line_cnt);
        end
    end

    // The *_eff terms fold this cycle's HS/BLANK edges into the frame that a
    // coincident VS edge is about to close.
    logic [10:0] hcnt, run_cnt, hs_cnt, hs_cnt_eff;
    logic [9:0]  lines_eff;
    logic        period_bad, run_bad, period_bad_eff, run_bad_eff, frame_good;

    assign hs_cnt_eff     = hs_fall ? inc11(hs_cnt) : hs_cnt;
    assign period_bad_eff = period_bad | (hs_fall & (hcnt != 11'(H_TOTAL)));
    assign run_bad_eff    = run_bad | (blank_fall & (run_cnt != 11'(H_ACTIVE)));
    assign lines_eff      = blank_fall ? inc10(line_cnt) : line_cnt;
    assign frame_good     = !period_bad_eff && !run_bad_eff &&
                            (hs_cnt_eff == 11'(V_TOTAL)) && (lines_eff == 10'(V_ACTIVE));

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hcnt          <= 11'd0;
            run_cnt       <= 11'd0;
            hs_cnt        <= 11'd0;
            period_bad    <= 1'b0;
            run_bad       <= 1'b0;
            oLINE_LEN     <= 11'd0;
            oACTIVE_LINES <= 10'd0;
        end else begin
            if (hs_fall) begin
                oLINE_LEN <= hcnt;
                hcnt      <= 11'd1;
            end else begin
                hcnt <= inc11(hcnt);
            end
            run_cnt <= blank_s1 ? inc11(run_cnt) : 11'd0;
            if (vs_fall) begin
                hs_cnt        <= 11'd0;
                period_bad    <= 1'b0;
                run_bad       <= 1'b0;
                oACTIVE_LINES <= lines_eff;
            end else begin
                hs_cnt     <= hs_cnt_eff;
                period_bad <= period_bad_eff;
                run_bad    <= run_bad_eff;
            end
        end
    end

    // Free-running watchdog restarted by every VS edge; rearms itself after firing.
    logic [19:0] to_cnt;
    logic        to_hit;

    assign to_hit = !vs_fall && (to_cnt >= 20'(TIMEOUT));

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n)
            to_cnt <= 20'd0;
        else if (vs_fall)
            to_cnt <= 20'd1;
        else if (to_hit)
            to_cnt <= 20'd0;
        else
            to_cnt <= to_cnt + 20'd1;
    end

    state_t     state;
    logic [2:0] good_cnt;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state        <= SEARCH;
            good_cnt     <= 3'd0;
            oLOCKED      <= 1'b0;
            oERR         <= 1'b0;
            oERR_CNT     <= 8'd0;
            oFRAME_START <= 1'b0;
        end else begin
            oFRAME_START <= vs_fall;
            oERR         <= 1'b0;
            if (to_hit) begin
                state    <= SEARCH;
                good_cnt <= 3'd0;
                oLOCKED  <= 1'b0;
                if (state == LOCKED) begin
                    oERR     <= 1'b1;
                    oERR_CNT <= (oERR_CNT == 8'hFF) ? oERR_CNT : oERR_CNT + 8'd1;
                end
            end else if (vs_fall) begin
                case (state)
                    SEARCH: begin
                        state    <= TRACK;
                        good_cnt <= 3'd0;
                    end
                    TRACK: begin
                        if (frame_good) begin
                            good_cnt <= good_cnt + 3'd1;
                            if (good_cnt + 3'd1 >= 3'(LOCK_FRAMES)) begin
                                state   <= LOCKED;
                                oLOCKED <= 1'b1;
                            end
                        end else begin
                            good_cnt <= 3'd0;
                        end
                    end
                    LOCKED: begin
                        if (!frame_good) begin
                            state    <= TRACK;
                            good_cnt <= 3'd0;
                            oLOCKED  <= 1'b0;
                            oERR     <= 1'b1;
                            oERR_CNT <= (oERR_CNT == 8'hFF) ? oERR_CNT : oERR_CNT + 8'd1;
                        end
                    end
                    default: begin
                        state    <= SEARCH;
                        good_cnt <= 3'd0;
                        oLOCKED  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef VGA_FRAME_CRC_EN
    logic [23:0] rgb_s1;
    logic [15:0] crc_run, crc_next;

    // CRC-16-CCITT, 24 data bits per step, MSB of R first.
    function automatic logic [15:0] crc24(input logic [15:0] crc_in, input logic [23:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 23; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    assign crc_next = blank_s1 ? crc24(crc_run, rgb_s1) : crc_run;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            rgb_s1     <= 24'd0;
            crc_run    <= 16'hFFFF;
            oFRAME_CRC <= 16'd0;
            oCRC_VALID <= 1'b0;
        end else begin
            rgb_s1 <= {iR, iG, iB};
            if (vs_fall) begin
                oFRAME_CRC <= crc_next;
                crc_run    <= 16'hFFFF;
                oCRC_VALID <= (state != SEARCH) && frame_good;
            end else begin
                crc_run <= crc_next;
            end
        end
    end
`else
    logic unused_rgb;
    assign unused_rgb = ^{iR, iG, iB};
    assign oFRAME_CRC = 16'd0;
    assign oCRC_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Scoreboard bench for vga_timing_monitor on a scaled 16x6 active / 24x10 total raster.
module tb_vga_timing_monitor;

    localparam int H_ACT = 16;
    localparam int H_TOT = 24;
    localparam int V_ACT = 6;
    localparam int V_TOT = 10;
    localparam int TMO   = 600;
`ifdef VGA_FRAME_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic        clk, rst_n, hs, vs, blank;
    logic [7:0]  r, g, b;
    logic        de, frame_start, locked, err, crc_valid;
    logic [9:0]  x, y, active_lines;
    logic [10:0] line_len;
    logic [7:0]  err_cnt;
    logic [15:0] frame_crc;
    logic [69:0] all_out;

    vga_timing_monitor #(
        .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .H_TOTAL(H_TOT), .V_TOTAL(V_TOT),
        .LOCK_FRAMES(2), .TIMEOUT(TMO)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iHS(hs), .iVS(vs), .iBLANK_n(blank),
        .iR(r), .iG(g), .iB(b),
        .oDE(de), .oX(x), .oY(y), .oFRAME_START(frame_start), .oLOCKED(locked),
        .oERR(err), .oLINE_LEN(line_len), .oACTIVE_LINES(active_lines),
        .oERR_CNT(err_cnt), .oFRAME_CRC(frame_crc), .oCRC_VALID(crc_valid)
    );

    assign all_out = {de, x, y, frame_start, locked, err, line_len, active_lines,
                      err_cnt, frame_crc, crc_valid};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        locked;
        logic        err;
        logic [7:0]  err_cnt;
        logic        chk_len;
        logic [9:0]  lines;
        logic [15:0] crc;
        logic        crc_valid;
    } frame_exp_t;

    frame_exp_t  frame_q[$];
    logic [19:0] pix_q[$];
    logic [7:0]  err_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ycount  = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bytewise reference CRC-16-CCITT over npix all-zero RGB pixels.
    function automatic logic [15:0] model_crc(input int npix);
        logic [15:0] c;
        logic [7:0]  byte_v;
        c      = 16'hFFFF;
        byte_v = 8'h00;
        for (int p = 0; p < npix * 3; p++) begin
            c = c ^ {byte_v, 8'h00};
            for (int k = 0; k < 8; k++)
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    function automatic frame_exp_t mk(input bit lk, input bit er, input int cnt,
                                      input bit chk_len, input int lines, input bit cv);
        frame_exp_t f;
        f.locked    = lk;
        f.err       = er;
        f.err_cnt   = 8'(cnt);
        f.chk_len   = chk_len;
        f.lines     = 10'(lines);
        f.crc       = CRC_EN ? model_crc(lines * H_ACT) : 16'h0000;
        f.crc_valid = CRC_EN & cv;
        return f;
    endfunction

    // Monitor: pops an expectation whenever the DUT presents a pixel, frame pulse or error.
    frame_exp_t  fe_m;
    logic [19:0] px_m;
    always @(negedge clk) begin
        if (rst_n) begin
            if (de) begin
                if (pix_q.size() == 0) begin
                    chk("pix_unexpected_de", 1, 0);
                end else begin
                    px_m = pix_q.pop_front();
                    chk("pix_x", x, px_m[19:10]);
                    chk("pix_y", y, px_m[9:0]);
                end
            end
            if (frame_start) begin
                if (frame_q.size() == 0) begin
                    chk("fs_unexpected", 1, 0);
                end else begin
                    fe_m = frame_q.pop_front();
                    $display("[TB] frame pulse t=%0t locked=%0d err=%0d err_cnt=%0d lines=%0d len=%0d crc=%h v=%0d",
                             $time, locked, err, err_cnt, active_lines, line_len, frame_crc, crc_valid);
                    chk("fs_locked", locked, fe_m.locked);
                    chk("fs_err", err, fe_m.err);
                    chk("fs_err_cnt", err_cnt, fe_m.err_cnt);
                    chk("fs_active_lines", active_lines, fe_m.lines);
                    if (fe_m.chk_len) chk("fs_line_len", line_len, H_TOT);
                    chk("fs_crc", frame_crc, fe_m.crc);
                    chk("fs_crc_valid", crc_valid, fe_m.crc_valid);
                end
            end
            if (err) begin
                if (err_q.size() == 0) chk("err_unexpected", 1, 0);
                else chk("err_pulse_cnt", err_cnt, err_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            hs = 1'b1; vs = 1'b1; blank = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // One raster frame. vs_en=0 holds VS high; bad_line gets one extra clock;
    // rst_line pulses reset for 3 clocks inside that line's blanking.
    task automatic send_frame(input bit vs_en, input int bad_line, input int rst_line,
                              input frame_exp_t fe, input bit exp_err);
        int len;
        for (int l = 0; l < V_TOT; l++) begin
            len = (l == bad_line) ? H_TOT + 1 : H_TOT;
            for (int h = 0; h < len; h++) begin
                if (l == rst_line && h == 10) begin
                    rst_n = 1'b0;
                    #1;
                    chk("async_reset_outputs", all_out, 0);
                    pix_q.delete();
                    frame_q.delete();
                    err_q.delete();
                    ycount = 0;
                end
                if (l == rst_line && h == 13) rst_n = 1'b1;
                hs    = !(h < 4);
                vs    = !(vs_en && l == 0 && h < H_TOT);
                blank = (l >= 2) && (l < 2 + V_ACT) && (h >= 6) && (h < 6 + H_ACT);
                if (vs_en && l == 0 && h == 0) begin
                    frame_q.push_back(fe);
                    if (exp_err) err_q.push_back(fe.err_cnt);
                    ycount = 0;
                end
                if (blank) pix_q.push_back({10'(h - 6), 10'(ycount)});
                @(posedge clk); #1;
            end
            if (l >= 2 && l < 2 + V_ACT) ycount++;
        end
    endtask

    initial begin
        rst_n = 1'b0; hs = 1'b1; vs = 1'b1; blank = 1'b0; r = 8'h00; g = 8'h00; b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_out, 0);
        rst_n = 1'b1;
        idle(10);

        send_frame(1, -1, -1, mk(0, 0, 0, 0, 0, 0), 0);
        send_frame(1, -1, -1, mk(0, 0, 0, 1, 6, 1), 0);
        send_frame(1, -1, -1, mk(1, 0, 0, 1, 6, 1), 0);
        send_frame(1,  3, -1, mk(1, 0, 0, 1, 6, 1), 0);
        send_frame(1, -1, -1, mk(0, 1, 1, 1, 6, 0), 1);
        send_frame(1, -1, -1, mk(0, 0, 1, 1, 6, 1), 0);
        send_frame(1, -1, -1, mk(1, 0, 1, 1, 6, 1), 0);
        send_frame(1, -1, -1, mk(1, 0, 1, 1, 6, 1), 0);

        err_q.push_back(8'd2);
        repeat (3) send_frame(0, -1, -1, mk(0, 0, 0, 0, 0, 0), 0);
        chk("timeout_locked", locked, 0);
        chk("timeout_err_cnt", err_cnt, 2);
        chk("timeout_err_seen", err_q.size(), 0);

        send_frame(1, -1, -1, mk(0, 0, 2, 1, 24, 0), 0);
        send_frame(1, -1, -1, mk(0, 0, 2, 1, 6, 1), 0);
        send_frame(1, -1,  9, mk(1, 0, 2, 1, 6, 1), 0);
        send_frame(1, -1, -1, mk(0, 0, 0, 0, 0, 0), 0);
        send_frame(1, -1, -1, mk(0, 0, 0, 1, 6, 1), 0);
        send_frame(1, -1, -1, mk(1, 0, 0, 1, 6, 1), 0);
        send_frame(1, -1, -1, mk(1, 0, 0, 1, 6, 1), 0);
        idle(5);

        chk("pix_q_drained", pix_q.size(), 0);
        chk("frame_q_drained", frame_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
